// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry in-order issue buffer (main + skid) in front of the ALU.
// Ops are accepted on in_valid & in_ready and presented on out_* from the head
// entry register. While an op waits, writeback results are forwarded into its
// register-sourced operands.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   defined   -> writeback forwarding into held and incoming operands
//   undefined -> fwd_* ports are ignored, operands pass through unmodified
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   flush                  drop all held ops and any same-cycle push
//   in_valid/in_ready      upstream handshake
//   in_a, in_b             operands (WIDTH)
//   in_ctrl                ALU control code (4), passed through
//   in_rd/in_rs1/in_rs2    register indices (5)
//   in_use_rs1/in_use_rs2  operand a/b sourced from a register
//   fwd_valid/fwd_rd/fwd_data  writeback result for forwarding
//   out_valid/out_ready    downstream handshake
//   out_a/out_b/out_ctrl/out_rd  head entry fields (registered)
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_ctrl,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic             fwd_valid,
  input  logic [4:0]       fwd_rd,
  input  logic [WIDTH-1:0] fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [3:0]       out_ctrl,
  output logic [4:0]       out_rd
);

  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctrl;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             use_rs1;
    logic             use_rs2;
  } entry_t;

  entry_t           ent_q [2];
  entry_t           ent_d [2];
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  entry_t           held0, held1, inc;
  logic [CNT_W-1:0] cnt_after_pop;
  logic             push, pop;

`ifdef ALU_ISSUE_FWD_EN
  // Replace register-sourced operands with the writeback value on an index match; x0 is never forwarded.
  function automatic entry_t fwd_apply(input entry_t e, input logic fv,
                                       input logic [4:0] frd, input logic [WIDTH-1:0] fdata);
    entry_t r;
    r = e;
    if (fv && (frd != 5'd0)) begin
      if (e.use_rs1 && (e.rs1 == frd)) r.a = fdata;
      if (e.use_rs2 && (e.rs2 == frd)) r.b = fdata;
    end
    return r;
  endfunction
`else
  function automatic entry_t fwd_apply(input entry_t e, input logic fv,
                                       input logic [4:0] frd, input logic [WIDTH-1:0] fdata);
    return e;
  endfunction
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
`endif

  // Handshakes decoded from registered state only.
  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Next-state: pop shifts entry 1 into the head, push fills the first free slot.
  always_comb begin
    inc.a       = in_a;
    inc.b       = in_b;
    inc.ctrl    = in_ctrl;
    inc.rd      = in_rd;
    inc.rs1     = in_rs1;
    inc.rs2     = in_rs2;
    inc.use_rs1 = in_use_rs1;
    inc.use_rs2 = in_use_rs2;
    inc         = fwd_apply(inc, fwd_valid, fwd_rd, fwd_data);
    held0       = fwd_apply(ent_q[0], fwd_valid, fwd_rd, fwd_data);
    held1       = fwd_apply(ent_q[1], fwd_valid, fwd_rd, fwd_data);

    ent_d[0]      = held0;
    ent_d[1]      = held1;
    count_d       = count_q;
    cnt_after_pop = count_q;

    if (flush) begin
      count_d = '0;
    end else begin
      cnt_after_pop = count_q - CNT_W'(pop);
      if (pop) ent_d[0] = held1;
      if (push) begin
        if (cnt_after_pop == '0) ent_d[0] = inc;
        else                     ent_d[1] = inc;
      end
      count_d = cnt_after_pop + CNT_W'(push);
    end

    out_valid_d = (count_d != '0);
    in_ready_d  = (count_d < CNT_W'(DEPTH));
  end

  // State registers; reset clears everything including entry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q[0]    <= '0;
      ent_q[1]    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      ent_q[0]    <= ent_d[0];
      ent_q[1]    <= ent_d[1];
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = ent_q[0].a;
  assign out_b     = ent_q[0].b;
  assign out_ctrl  = ent_q[0].ctrl;
  assign out_rd    = ent_q[0].rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed ops push expected head fields
// into a queue; a negedge monitor pops and compares on every accepted output.
module tb_alu_issue_stage;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [3:0]   in_ctrl = '0;
  logic [4:0]   in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic         in_use_rs1 = 1'b0, in_use_rs2 = 1'b0;
  logic         fwd_valid = 1'b0;
  logic [4:0]   fwd_rd = '0;
  logic [W-1:0] fwd_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a, out_b;
  logic [3:0]   out_ctrl;
  logic [4:0]   out_rd;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ctrl;
    logic [4:0]   rd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  alu_issue_stage #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctrl,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
    in_valid = 1'b1; in_a = a; in_b = b; in_ctrl = ctrl; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_use_rs1 = u1; in_use_rs2 = u2;
  endtask

  task automatic expect_out(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] ctrl, input logic [4:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.ctrl = ctrl; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted output must match the oldest expected op.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got a=0x%0h rd=%0d expected none", out_a, out_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_a", out_a, e.a);
        chk("sb_b", out_b, e.b);
        chk("sb_ctrl", W'(out_ctrl), W'(e.ctrl));
        chk("sb_rd", W'(out_rd), W'(e.rd));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_fwd_a, exp_fwd_b;
    // Reset values, asserted before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_out_a", out_a, '0);
    chk("rst_out_b", out_b, '0);
    chk("rst_out_ctrl", W'(out_ctrl), '0);
    chk("rst_out_rd", W'(out_rd), '0);
    cyc(); cyc();
    reset = 1'b0;
    chk("post_rst_in_ready", W'(in_ready), W'(1'b1));

    // Single op with out_ready high.
    out_ready = 1'b1;
    drive_op(32'd5, 32'd7, 4'b0000, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    expect_out(32'd5, 32'd7, 4'b0000, 5'd3);
    cyc();
    in_valid = 1'b0;
    chk("single_out_valid", W'(out_valid), W'(1'b1));
    cyc();
    chk("single_drained", W'(out_valid), W'(1'b0));

    // Fill both entries under backpressure; third op must be ignored.
    out_ready = 1'b0;
    drive_op(32'd1, 32'd10, 4'h1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    expect_out(32'd1, 32'd10, 4'h1, 5'd1);
    cyc();
    chk("one_in_ready", W'(in_ready), W'(1'b1));
    drive_op(32'd2, 32'd20, 4'h2, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    expect_out(32'd2, 32'd20, 4'h2, 5'd2);
    cyc();
    chk("full_in_ready", W'(in_ready), W'(1'b0));
    drive_op(32'd3, 32'd30, 4'h3, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc();
    chk("full_hold_in_ready", W'(in_ready), W'(1'b0));
    chk("full_hold_head_a", out_a, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("after_pop_in_ready", W'(in_ready), W'(1'b1));
    chk("after_pop_head_a", out_a, 32'd2);
    cyc();
    chk("drained2", W'(out_valid), W'(1'b0));

    // Forwarding into a held op's operand a.
`ifdef ALU_ISSUE_FWD_EN
    exp_fwd_a = 32'hDEADBEEF;
`else
    exp_fwd_a = 32'h0;
`endif
    out_ready = 1'b0;
    drive_op(32'h0, 32'd9, 4'h2, 5'd6, 5'd4, 5'd0, 1'b1, 1'b0);
    expect_out(exp_fwd_a, 32'd9, 4'h2, 5'd6);
    cyc();
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 5'd4; fwd_data = 32'hDEADBEEF;
    cyc();
    fwd_valid = 1'b0;
    chk("fwd_held_a", out_a, exp_fwd_a);
    chk("fwd_held_ctrl", W'(out_ctrl), W'(4'h2));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // x0 never forwarded; b not forwarded when use_rs2=0.
    drive_op(32'h11, 32'h22, 4'h5, 5'd7, 5'd0, 5'd5, 1'b1, 1'b0);
    expect_out(32'h11, 32'h22, 4'h5, 5'd7);
    cyc();
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 5'd0; fwd_data = 32'hFFFF;
    cyc();
    fwd_rd = 5'd5;
    cyc();
    fwd_valid = 1'b0;
    chk("x0_no_fwd_a", out_a, 32'h11);
    chk("norf_no_fwd_b", out_b, 32'h22);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Forwarding onto the op being pushed in the same cycle (operand b), rd untouched.
`ifdef ALU_ISSUE_FWD_EN
    exp_fwd_b = 32'hCAFE;
`else
    exp_fwd_b = 32'h33;
`endif
    drive_op(32'h44, 32'h33, 4'h7, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1);
    fwd_valid = 1'b1; fwd_rd = 5'd7; fwd_data = 32'hCAFE;
    expect_out(32'h44, exp_fwd_b, 4'h7, 5'd7);
    cyc();
    in_valid = 1'b0; fwd_valid = 1'b0;
    chk("fwd_push_b", out_b, exp_fwd_b);
    chk("fwd_push_rd", W'(out_rd), W'(5'd7));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Flush at count=2 with in_valid high: nothing survives.
    drive_op(32'hA1, 32'h0, 4'h0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc();
    drive_op(32'hA2, 32'h0, 4'h0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc();
    drive_op(32'hA3, 32'h0, 4'h0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", W'(out_valid), W'(1'b0));
    chk("flush2_in_ready", W'(in_ready), W'(1'b1));

    // Flush at count=1 with an acceptable push: the push is dropped.
    drive_op(32'hB1, 32'h0, 4'h0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc();
    drive_op(32'hB2, 32'h0, 4'h0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_out_valid", W'(out_valid), W'(1'b0));
    out_ready = 1'b1;
    cyc(); cyc();
    out_ready = 1'b0;

    // Asynchronous reset mid-cycle with one op held.
    drive_op(32'hC1, 32'hC2, 4'hF, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("pre_arst_out_valid", W'(out_valid), W'(1'b1));
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", W'(out_valid), W'(1'b0));
    chk("arst_out_a", out_a, '0);
    chk("arst_out_b", out_b, '0);
    chk("arst_out_ctrl", W'(out_ctrl), '0);
    chk("arst_out_rd", W'(out_rd), '0);
    cyc();
    reset = 1'b0;
    chk("arst_in_ready", W'(in_ready), W'(1'b1));
    out_ready = 1'b1;
    cyc(); cyc();

    chk("sb_queue_empty", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
